// File: rtl/arb_mux.sv
// N-channel valid/ready arbiter (round-robin or fixed priority) feeding a single output register.
// One cycle from grant to out_valid; when the output word is stalled, every in_ready stays low.
module arb_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_win;
  logic [SEL_W-1:0] fp_win;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] nxt_ptr;
  logic             any_vld;
  logic             can_load;
  logic             grant;
  int               rr_idx;

  assign any_vld   = |in_valid;
  assign out_valid = (state_q == FULL);
  assign can_load  = (state_q == EMPTY) | out_ready;
  assign grant     = can_load & any_vld & ~reset;

  // Descending scan: the last hit, i.e. the closest to rr_ptr, wins.
  always_comb begin
    rr_win = '0;
    rr_idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr) + k;
      if (rr_idx >= NUM_CH) rr_idx = rr_idx - NUM_CH;
      if (in_valid[rr_idx]) rr_win = SEL_W'(rr_idx);
    end
  end

  always_comb begin
    fp_win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) fp_win = SEL_W'(i);
    end
  end

  assign win     = mode ? fp_win : rr_win;
  assign nxt_ptr = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (can_load) state_d = any_vld ? FULL : EMPTY;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (can_load && any_vld) begin
        out_data <= in_data[int'(win)*WIDTH +: WIDTH];
        out_sel  <= win;
        rr_ptr   <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: round-robin, fixed priority, wrap, backpressure, drain and reset.
module tb_arb_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_CH = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic [2:0]              out_sel;
  logic                    out_valid;
  logic                    out_ready;

  logic [WIDTH-1:0] chdat [NUM_CH];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign in_data[g*WIDTH +: WIDTH] = chdat[g];
  end

  arb_mux #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] s, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".sel"},   64'(out_sel),   64'(s));
    chk({tag, ".data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) chdat[i] = 32'hC0DE_0000 | i;
    chdat[3]  = 32'hDEAD_BEEF;
    reset     = 1'b1;
    in_valid  = 8'hFF;
    mode      = 1'b0;
    out_ready = 1'b1;

    // Reset state, with requests pending
    step();
    step();
    chk("rst_ready", 64'(in_ready), 64'h0);
    chk_out("rst", 1'b0, 3'd0, 32'h0);

    // Round-robin sweep 0..7,0
    reset = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rr_ready%0d", i), 64'(in_ready), 64'(8'h01 << (i % 8)));
      step();
      chk_out($sformatf("rr%0d", i), 1'b1, 3'(i % 8), chdat[i % 8]);
    end

    // Fixed priority: channel 2 always wins (rr_ptr ends at 3)
    mode     = 1'b1;
    in_valid = 8'b1010_0100;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fp_ready%0d", i), 64'(in_ready), 64'h04);
      step();
      chk_out($sformatf("fp%0d", i), 1'b1, 3'd2, chdat[2]);
    end

    // Backpressure on channel 3's word (rr_ptr ends at 4)
    mode     = 1'b0;
    in_valid = 8'b0000_1000;
    #1;
    chk("bp_grant", 64'(in_ready), 64'h08);
    step();
    chk_out("bp_load", 1'b1, 3'd3, 32'hDEAD_BEEF);
    out_ready = 1'b0;
    in_valid  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 64'(in_ready), 64'h0);
      step();
      chk_out($sformatf("bp%0d", i), 1'b1, 3'd3, 32'hDEAD_BEEF);
    end

    // Empty drain: valid falls, data and sel hold
    out_ready = 1'b1;
    in_valid  = 8'h00;
    #1;
    chk("drain_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("drain", 1'b0, 3'd3, 32'hDEAD_BEEF);
    step();
    chk_out("drain_idle", 1'b0, 3'd3, 32'hDEAD_BEEF);

    // Wrap: rr_ptr 4 -> grant 5 -> rr_ptr 6; then 7 before 1
    in_valid = 8'b0010_0000;
    #1;
    chk("wrap_pre_ready", 64'(in_ready), 64'h20);
    step();
    chk_out("wrap_pre", 1'b1, 3'd5, chdat[5]);
    in_valid = 8'b1000_0010;
    #1;
    chk("wrap_ready7", 64'(in_ready), 64'h80);
    step();
    chk_out("wrap7", 1'b1, 3'd7, chdat[7]);
    #1;
    chk("wrap_ready1", 64'(in_ready), 64'h02);
    step();
    chk_out("wrap1", 1'b1, 3'd1, chdat[1]);
    // rr_ptr must now be 2
    in_valid = 8'hFF;
    #1;
    chk("wrap_ptr2", 64'(in_ready), 64'h04);
    step();
    chk_out("wrap2", 1'b1, 3'd2, chdat[2]);

    // Mode change seen on the very next arbitration (rr_ptr 3)
    #1;
    chk("mode_rr", 64'(in_ready), 64'h08);
    mode = 1'b1;
    #1;
    chk("mode_fp", 64'(in_ready), 64'h01);
    step();
    chk_out("mode_fp_out", 1'b1, 3'd0, chdat[0]);

    // Reset mid-operation, held word discarded, pointer back to 0
    mode     = 1'b0;
    reset    = 1'b1;
    in_valid = 8'hFF;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
    step();
    chk_out("mid_rst", 1'b0, 3'd0, 32'h0);
    reset    = 1'b0;
    in_valid = 8'b0110_0000;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'h20);
    step();
    chk_out("post_rst", 1'b1, 3'd5, chdat[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
